// File: rtl/pipe_field_pkg.sv
// rtl/pipe_field_pkg.sv - shared types and geometry for the pipe_field scrolling playfield
package pipe_field_pkg;

    localparam int NUM_COLS = 16;
    localparam int NUM_ROWS = 8;

    typedef logic [NUM_ROWS-1:0] col_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        CRASH = 2'd2
    } state_t;

endpackage

// File: rtl/pipe_field_scroll_tick.sv
// rtl/pipe_field_scroll_tick.sv - free-running scroll period counter with enable and clear
module scroll_tick #(
    parameter int PERIOD = 1024
) (
    input  logic clk,
    input  logic reset,
    input  logic i_en,
    input  logic i_clr,
    output logic o_tick
);

    localparam int CW = $clog2(PERIOD);
    localparam logic [CW-1:0] LAST = CW'(PERIOD - 1);

    logic [CW-1:0] r_count;

    // Tick only while enabled so a frozen counter never shifts the field
    assign o_tick = i_en && (r_count == LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_en) begin
            r_count <= o_tick ? '0 : r_count + 1'b1;
        end
    end

endmodule

// File: rtl/pipe_field.sv
// rtl/pipe_field.sv - scrolling pipe field with bird collision; score counter built only with PIPE_FIELD_SCORE_EN
module pipe_field
    import pipe_field_pkg::*;
#(
    parameter int SCROLL_PERIOD = 1024,
    parameter int BIRD_COL      = 13
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [7:0]                   location,
    input  logic                         new_col,
    input  logic [7:0]                   bird,
    input  logic                         start,
    output logic [NUM_COLS*NUM_ROWS-1:0] field,
    output logic                         crash,
    output logic [7:0]                   score
);

    state_t r_state;
    state_t w_state_next;
    col_t   r_cols [NUM_COLS];
    col_t   r_pending;
    logic   r_pending_valid;
    logic   w_tick;
    logic   w_run;
    logic   w_idle;
    logic   w_collide;
    logic   w_clear;

    assign w_run     = (r_state == RUN);
    assign w_idle    = (r_state == IDLE);
    assign w_collide = w_run && ((r_cols[BIRD_COL] & bird) != '0);
    // Restart from CRASH wipes the field on the same edge that enters IDLE
    assign w_clear   = w_idle || ((r_state == CRASH) && start);

    scroll_tick #(
        .PERIOD (SCROLL_PERIOD)
    ) u_scroll_tick (
        .clk    (clk),
        .reset  (reset),
        .i_en   (w_run),
        .i_clr  (w_idle),
        .o_tick (w_tick)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (start)     w_state_next = RUN;
            RUN:     if (w_collide) w_state_next = CRASH;
            CRASH:   if (start)     w_state_next = IDLE;
            default:                w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int c = 0; c < NUM_COLS; c++) r_cols[c] <= '0;
            r_pending       <= '0;
            r_pending_valid <= 1'b0;
        end else if (w_clear) begin
            for (int c = 0; c < NUM_COLS; c++) r_cols[c] <= '0;
            r_pending       <= '0;
            r_pending_valid <= 1'b0;
        end else if (w_tick) begin
            for (int c = NUM_COLS - 1; c > 0; c--) r_cols[c] <= r_cols[c-1];
            // A strobe coincident with the tick beats any older pending column
            r_cols[0]       <= new_col ? location : (r_pending_valid ? r_pending : '0);
            r_pending_valid <= 1'b0;
        end else if (w_run && new_col) begin
            r_pending       <= location;
            r_pending_valid <= 1'b1;
        end
    end

    always_comb begin
        field = '0;
        for (int c = 0; c < NUM_COLS; c++) field[c*NUM_ROWS +: NUM_ROWS] = r_cols[c];
    end

    assign crash = (r_state == CRASH);

`ifdef PIPE_FIELD_SCORE_EN
    logic [7:0] r_score;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_score <= 8'h00;
        end else if (w_clear) begin
            r_score <= 8'h00;
        end else if (w_tick && (r_cols[BIRD_COL] != '0) && !w_collide && (r_score != 8'hFF)) begin
            r_score <= r_score + 8'h01;
        end
    end

    assign score = r_score;
`else
    assign score = 8'h00;
`endif

endmodule

// File: tb/tb_pipe_field.sv
// tb/tb_pipe_field.sv - self-checking bench for pipe_field against a behavioural game model
module tb_pipe_field;

    localparam int P  = 4;
    localparam int BC = 13;
    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_CRASH = 2;

    logic         clk = 1'b0;
    logic         reset;
    logic [7:0]   location;
    logic         new_col;
    logic [7:0]   bird;
    logic         start;
    logic [127:0] field;
    logic         crash;
    logic [7:0]   score;

    always #5 clk = ~clk;

    pipe_field #(
        .SCROLL_PERIOD (P),
        .BIRD_COL      (BC)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .location (location),
        .new_col  (new_col),
        .bird     (bird),
        .start    (start),
        .field    (field),
        .crash    (crash),
        .score    (score)
    );

    int n_checks = 0;
    int n_fail   = 0;
    bit score_en;

    int       m_mode;
    int       m_phase;
    int       m_score;
    bit [7:0] m_cols [16];
    bit [7:0] m_pend;
    bit       m_pv;

    function automatic void model_clear();
        for (int c = 0; c < 16; c++) m_cols[c] = 8'h00;
        m_pend  = 8'h00;
        m_pv    = 1'b0;
        m_phase = 0;
        m_score = 0;
    endfunction

    // One clock of game rules, applied to the inputs present before the edge
    task automatic model_step();
        bit tick;
        bit hit;
        if (reset) begin
            model_clear();
            m_mode = M_IDLE;
            return;
        end
        case (m_mode)
            M_IDLE: begin
                model_clear();
                if (start) m_mode = M_RUN;
            end
            M_RUN: begin
                hit     = (m_cols[BC] & bird) != 8'h00;
                tick    = (m_phase == P - 1);
                m_phase = (m_phase + 1) % P;
                if (tick) begin
                    if (m_cols[BC] != 8'h00 && !hit && m_score < 255) m_score++;
                    for (int c = 15; c > 0; c--) m_cols[c] = m_cols[c-1];
                    m_cols[0] = new_col ? location : (m_pv ? m_pend : 8'h00);
                    m_pv = 1'b0;
                end else if (new_col) begin
                    m_pend = location;
                    m_pv   = 1'b1;
                end
                if (hit) m_mode = M_CRASH;
            end
            default: begin
                if (start) begin
                    model_clear();
                    m_mode = M_IDLE;
                end
            end
        endcase
    endtask

    function automatic logic [127:0] exp_field();
        logic [127:0] f;
        f = '0;
        for (int c = 0; c < 16; c++) f[8*c +: 8] = m_cols[c];
        return f;
    endfunction

    function automatic logic [7:0] exp_score();
        return score_en ? 8'(m_score) : 8'h00;
    endfunction

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; new_col = 1'b0; location = 8'h00; bird = 8'h00;
        model_clear(); m_mode = M_IDLE;
        repeat (3) cycle();
        reset = 1'b0;
        for (int i = 0; i < 50; i++) begin
            new_col  = 1'($urandom_range(0, 1));
            location = 8'($urandom);
            bird     = 8'($urandom);
            cycle();
            n_checks++;
            if (field !== 128'h0) begin n_fail++; $display("FAIL reset_field: got %h expected 0", field); end
            n_checks++;
            if (crash !== 1'b0) begin n_fail++; $display("FAIL reset_crash: got %b expected 0", crash); end
            n_checks++;
            if (score !== 8'h00) begin n_fail++; $display("FAIL reset_score: got %h expected 00", score); end
        end
        new_col = 1'b0; bird = 8'h00;
    endtask

    task automatic test_scroll();
        start = 1'b1;
        cycle();
        start = 1'b0;
        new_col = 1'b1; location = 8'hC3;
        cycle();
        new_col = 1'b0; location = 8'h00;
        repeat (3) cycle();
        n_checks++;
        if (field[7:0] !== 8'hC3) begin n_fail++; $display("FAIL scroll_col0: got %h expected c3", field[7:0]); end
        n_checks++;
        if (field !== exp_field()) begin n_fail++; $display("FAIL scroll_field1: got %h expected %h", field, exp_field()); end
        repeat (4) cycle();
        n_checks++;
        if (field[15:8] !== 8'hC3) begin n_fail++; $display("FAIL scroll_col1: got %h expected c3", field[15:8]); end
        n_checks++;
        if (field[7:0] !== 8'h00) begin n_fail++; $display("FAIL scroll_col0_empty: got %h expected 00", field[7:0]); end
    endtask

    task automatic test_latest_wins();
        new_col = 1'b1; location = 8'h01;
        cycle();
        location = 8'h80;
        cycle();
        new_col = 1'b0; location = 8'h00;
        repeat (2) cycle();
        n_checks++;
        if (field[7:0] !== 8'h80) begin n_fail++; $display("FAIL latest_col0: got %h expected 80", field[7:0]); end
        for (int i = 0; i < 60; i++) begin
            cycle();
            n_checks++;
            if (field !== exp_field()) begin n_fail++; $display("FAIL latest_field: got %h expected %h", field, exp_field()); end
            for (int c = 0; c < 16; c++) begin
                n_checks++;
                if (field[8*c +: 8] === 8'h01) begin n_fail++; $display("FAIL latest_stale: col %0d got 01 expected not 01", c); end
            end
        end
        n_checks++;
        if (score !== exp_score()) begin n_fail++; $display("FAIL latest_score: got %h expected %h", score, exp_score()); end
    endtask

    task automatic launch_pipe(input logic [7:0] bird_v);
        reset = 1'b1; start = 1'b0; new_col = 1'b0; bird = bird_v;
        cycle();
        reset = 1'b0; start = 1'b1;
        cycle();
        start = 1'b0; new_col = 1'b1; location = 8'hC3;
        cycle();
        new_col = 1'b0; location = 8'h00;
    endtask

    task automatic test_score_crash();
        int n;
        logic [127:0] frozen;
        launch_pipe(8'h08);
        n = 0;
        while (m_cols[BC] != 8'hC3 && n < 200) begin cycle(); n++; end
        n_checks++;
        if (n >= 200) begin n_fail++; $display("FAIL pass_timeout: got %0d cycles expected < 200", n); end
        repeat (P) cycle();
        n_checks++;
        if (crash !== 1'b0) begin n_fail++; $display("FAIL pass_crash: got %b expected 0", crash); end
        n_checks++;
        if (score !== (score_en ? 8'h01 : 8'h00)) begin n_fail++; $display("FAIL pass_score: got %h expected %h", score, score_en ? 8'h01 : 8'h00); end
        n_checks++;
        if (field[8*(BC+1) +: 8] !== 8'hC3) begin n_fail++; $display("FAIL pass_col14: got %h expected c3", field[8*(BC+1) +: 8]); end

        launch_pipe(8'h01);
        n = 0;
        while (m_mode != M_CRASH && n < 200) begin cycle(); n++; end
        n_checks++;
        if (n >= 200) begin n_fail++; $display("FAIL crash_timeout: got %0d cycles expected < 200", n); end
        frozen = '0;
        frozen[8*BC +: 8] = 8'hC3;
        n_checks++;
        if (crash !== 1'b1) begin n_fail++; $display("FAIL crash_flag: got %b expected 1", crash); end
        n_checks++;
        if (score !== 8'h00) begin n_fail++; $display("FAIL crash_score: got %h expected 00", score); end
        for (int i = 0; i < 12; i++) begin
            new_col = 1'($urandom_range(0, 1)); location = 8'($urandom);
            cycle();
            n_checks++;
            if (field !== frozen) begin n_fail++; $display("FAIL crash_frozen: got %h expected %h", field, frozen); end
            n_checks++;
            if (crash !== 1'b1) begin n_fail++; $display("FAIL crash_hold: got %b expected 1", crash); end
        end
        new_col = 1'b0;
    endtask

    task automatic test_restart();
        start = 1'b1;
        cycle();
        start = 1'b0;
        n_checks++;
        if (crash !== 1'b0) begin n_fail++; $display("FAIL restart_crash: got %b expected 0", crash); end
        n_checks++;
        if (field !== 128'h0) begin n_fail++; $display("FAIL restart_field: got %h expected 0", field); end
        n_checks++;
        if (score !== 8'h00) begin n_fail++; $display("FAIL restart_score: got %h expected 00", score); end
        start = 1'b1; bird = 8'h00;
        for (int i = 0; i < 40; i++) begin
            new_col = 1'($urandom_range(0, 1)); location = 8'($urandom);
            cycle();
            n_checks++;
            if (field !== exp_field()) begin n_fail++; $display("FAIL start_in_run_field: got %h expected %h", field, exp_field()); end
            n_checks++;
            if (crash !== 1'b0) begin n_fail++; $display("FAIL start_in_run_crash: got %b expected 0", crash); end
        end
        start = 1'b0; new_col = 1'b0;
    endtask

    task automatic test_async_reset();
        bird = 8'h00;
        for (int i = 0; i < 70; i++) begin
            new_col = 1'b1; location = 8'($urandom_range(1, 255));
            cycle();
        end
        new_col = 1'b0;
        #3;
        reset = 1'b1;
        #1;
        n_checks++;
        if (field !== 128'h0) begin n_fail++; $display("FAIL async_field: got %h expected 0", field); end
        n_checks++;
        if (crash !== 1'b0) begin n_fail++; $display("FAIL async_crash: got %b expected 0", crash); end
        n_checks++;
        if (score !== 8'h00) begin n_fail++; $display("FAIL async_score: got %h expected 00", score); end
        cycle();
        reset = 1'b0;
        cycle();
        n_checks++;
        if (field !== 128'h0 || crash !== 1'b0) begin n_fail++; $display("FAIL async_release: got %h/%b expected 0/0", field, crash); end
    endtask

    task automatic test_saturate();
        reset = 1'b1; cycle(); reset = 1'b0;
        start = 1'b1; cycle(); start = 1'b0;
        bird = 8'h00;
        for (int i = 0; i < 300 * P; i++) begin
            new_col = 1'b1; location = 8'($urandom_range(1, 255));
            cycle();
            n_checks++;
            if (score !== exp_score()) begin n_fail++; $display("FAIL sat_track: got %h expected %h", score, exp_score()); end
        end
        new_col = 1'b0;
        n_checks++;
        if (score !== (score_en ? 8'hFF : 8'h00)) begin n_fail++; $display("FAIL sat_final: got %h expected %h", score, score_en ? 8'hFF : 8'h00); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 4000; i++) begin
            reset    = ($urandom_range(0, 399) == 0);
            start    = ($urandom_range(0, 11) == 0);
            new_col  = ($urandom_range(0, 2) == 0);
            location = 8'($urandom) & 8'($urandom);
            bird     = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'(1 << $urandom_range(0, 7));
            cycle();
            n_checks++;
            if (field !== exp_field()) begin n_fail++; $display("FAIL rand_field: got %h expected %h", field, exp_field()); end
            n_checks++;
            if (crash !== (m_mode == M_CRASH)) begin n_fail++; $display("FAIL rand_crash: got %b expected %b", crash, m_mode == M_CRASH); end
            n_checks++;
            if (score !== exp_score()) begin n_fail++; $display("FAIL rand_score: got %h expected %h", score, exp_score()); end
        end
        reset = 1'b0; start = 1'b0; new_col = 1'b0;
    endtask

    initial begin
`ifdef PIPE_FIELD_SCORE_EN
        score_en = 1'b1;
`else
        score_en = 1'b0;
`endif
        reset = 1'b1; start = 1'b0; new_col = 1'b0; location = 8'h00; bird = 8'h00;
        test_reset();
        test_scroll();
        test_latest_wins();
        test_score_crash();
        test_restart();
        test_async_reset();
        test_saturate();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
